// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader and its word packer.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_WR,
    ST_CSUM,
    ST_DONE
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int INSTR_W    = 32;
  localparam int BYTE_W     = 8;
  localparam int BCNT_W     = $clog2(WORD_BYTES);

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus instruction-memory write port seen by the loader.
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic [BYTE_W-1:0] in_data;
  logic              in_ready;
  logic              mem_write;
  logic              mem_mode;
  logic [ADDR_W-1:0] mem_addr;
  logic [INSTR_W-1:0] mem_data;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_write, mem_mode, mem_addr, mem_data
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_write, mem_mode, mem_addr, mem_data
  );
endinterface

// File: rtl/imem_word_packer.sv
// Big-endian byte-to-word shift register with byte counter and running XOR checksum.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               xor_en,
  input  logic               shift_en,
  input  logic [BYTE_W-1:0]  byte_in,
  output logic [INSTR_W-1:0] word,
  output logic               last,
  output logic [BYTE_W-1:0]  xor_acc
);

  logic [INSTR_W-1:0] word_reg;
  logic [BCNT_W-1:0]  cnt_reg;
  logic [BYTE_W-1:0]  xor_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_reg <= '0;
      cnt_reg  <= '0;
      xor_reg  <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
      xor_reg <= '0;
    end else begin
      // Shifted bytes also fold into the checksum; xor_en alone covers the length byte.
      if (xor_en || shift_en) begin
        xor_reg <= xor_reg ^ byte_in;
      end
      if (shift_en) begin
        word_reg <= {word_reg[INSTR_W-BYTE_W-1:0], byte_in};
        cnt_reg  <= cnt_reg + BCNT_W'(1);
      end
    end
  end

  assign word    = word_reg;
  assign last    = (cnt_reg == BCNT_W'(WORD_BYTES - 1));
  assign xor_acc = xor_reg;

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader: writes big-endian words to instruction memory, holds the CPU meanwhile.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
)
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         cpu_hold,
  output logic         done,
  output logic         err
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  state_t              state_reg, state_next;
  logic [BYTE_W-1:0]   len_reg;
  logic [BYTE_W-1:0]   wcnt_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic                err_reg;

  logic                xfer;
  logic                pk_last;
  logic [INSTR_W-1:0]  pk_word;
  logic [BYTE_W-1:0]   pk_xor;

  assign xfer = bus.in_valid & bus.in_ready;

  imem_word_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .clear    ((state_reg == ST_IDLE) && start),
    .xor_en   ((state_reg == ST_LEN) && xfer),
    .shift_en ((state_reg == ST_DATA) && xfer),
    .byte_in  (bus.in_data),
    .word     (pk_word),
    .last     (pk_last),
    .xor_acc  (pk_xor)
  );

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE: if (start) state_next = ST_LEN;
      ST_LEN:  if (xfer) state_next = (bus.in_data == '0) ? ST_CSUM : ST_DATA;
      ST_DATA: if (xfer && pk_last) state_next = ST_WR;
      ST_WR:   state_next = ((wcnt_reg + 8'd1) == len_reg) ? ST_CSUM : ST_DATA;
      ST_CSUM: if (xfer) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      len_reg   <= '0;
      wcnt_reg  <= '0;
      addr_reg  <= BASE;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      unique case (state_reg)
        ST_IDLE: if (start) begin
          err_reg  <= 1'b0;
          wcnt_reg <= '0;
          addr_reg <= BASE;
        end
        ST_LEN:  if (xfer) len_reg <= bus.in_data;
        ST_WR: begin
          addr_reg <= addr_reg + ADDR_W'(1);
          wcnt_reg <= wcnt_reg + 8'd1;
        end
        ST_CSUM: if (xfer) err_reg <= (bus.in_data != pk_xor);
        default: ;
      endcase
    end
  end

  // Every output is decoded from registered state so the byte source sees no combinational loop.
  assign bus.in_ready  = (state_reg == ST_LEN) || (state_reg == ST_DATA) || (state_reg == ST_CSUM);
  assign bus.mem_write = (state_reg == ST_WR);
  assign cpu_hold      = (state_reg == ST_LEN) || (state_reg == ST_DATA) ||
                         (state_reg == ST_WR)  || (state_reg == ST_CSUM);
  assign bus.mem_mode  = ~cpu_hold;
  assign bus.mem_addr  = addr_reg;
  assign bus.mem_data  = pk_word;
  assign done          = (state_reg == ST_DONE);
  assign err           = err_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench: two loaders (base 0 and base 254) share one byte stream.
module tb_imem_loader;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic err;
    int   cyc;
  } done_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       hold0, hold1, done0, done1, err0, err1;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  wr_t   exp0[$];
  wr_t   exp1[$];
  done_t expd[$];
  logic [31:0] wtab [0:3];

  imem_loader_if #(.ADDR_W(8)) w0 ();
  imem_loader_if #(.ADDR_W(8)) w1 ();

  assign w0.in_valid = in_valid;
  assign w0.in_data  = in_data;
  assign w1.in_valid = in_valid;
  assign w1.in_data  = in_data;

  imem_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .bus(w0),
    .cpu_hold(hold0), .done(done0), .err(err0)
  );

  imem_loader #(.ADDR_W(8), .BASE_ADDR(254)) dut1 (
    .clk(clk), .rst(rst), .start(start), .bus(w1),
    .cpu_hold(hold1), .done(done1), .err(err1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, {w0.in_ready, w1.in_ready}, 2'b00);
    chk({tag, "_wr"},    {w0.mem_write, w1.mem_write}, 2'b00);
    chk({tag, "_mode"},  {w0.mem_mode, w1.mem_mode}, 2'b11);
    chk({tag, "_addr0"}, w0.mem_addr, 8'd0);
    chk({tag, "_addr1"}, w1.mem_addr, 8'd254);
    chk({tag, "_data"},  {w0.mem_data, w1.mem_data}, 64'h0);
    chk({tag, "_ctl"},   {hold0, hold1, done0, done1, err0, err1}, 6'b0);
  endtask

  // Called at a falling edge; returns at the falling edge after the byte is accepted.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n = 0;
    if (gaps && ($urandom_range(0, 1) == 1)) begin
      in_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!w0.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL rdy_timeout: got in_ready=0 want in_ready=1 within 50 cycles");
    end
    @(negedge clk);
    $display("byte %02h accepted at cycle %0d", b, cyc);
  endtask

  task automatic frame(input int n, input logic [7:0] csum, input logic exp_err,
                       input bit gaps, input bit poke);
    done_t d;
    wr_t   e;
    int    k;
    start = 1'b1;
    d.err = exp_err;
    d.cyc = gaps ? -1 : cyc + 5 * n + 3;
    expd.push_back(d);
    for (int i = 0; i < n; i++) begin
      e.data = wtab[i];
      e.addr = 8'(i);
      exp0.push_back(e);
      e.addr = 8'(254 + i);
      exp1.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    chk("len_ready", w0.in_ready, 1'b1);
    chk("len_hold", {hold0, hold1}, 2'b11);
    chk("start_clears_err", {err0, err1}, 2'b00);
    send_byte(8'(n), gaps);
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 4; b++) begin
        if (poke && i == 0 && b == 1) start = 1'b1;
        send_byte(wtab[i][31 - 8 * b -: 8], gaps);
        start = 1'b0;
      end
    end
    send_byte(csum, gaps);
    in_valid = 1'b0;
    k = 0;
    while (!done0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got done=0 want done=1 within 20 cycles");
    end
    @(negedge clk);
  endtask

  // Monitor: pops expected writes and frame completions as the DUTs present them.
  initial begin
    wr_t   e;
    done_t d;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (w0.mem_write) begin
          if (exp0.size() == 0) chk("unexp_wr0", w0.mem_addr, 8'hxx);
          else begin
            e = exp0.pop_front();
            chk("addr0", w0.mem_addr, e.addr);
            chk("data0", w0.mem_data, e.data);
            chk("hold_in_wr", {hold0, w0.mem_mode}, 2'b10);
            $display("write dut0 addr=%0d data=%08h", w0.mem_addr, w0.mem_data);
          end
        end
        if (w1.mem_write) begin
          if (exp1.size() == 0) chk("unexp_wr1", w1.mem_addr, 8'hxx);
          else begin
            e = exp1.pop_front();
            chk("addr1", w1.mem_addr, e.addr);
            chk("data1", w1.mem_data, e.data);
            $display("write dut1 addr=%0d data=%08h", w1.mem_addr, w1.mem_data);
          end
        end
        if (done0) begin
          if (expd.size() == 0) chk("unexp_done", done0, 1'b0);
          else begin
            d = expd.pop_front();
            chk("done_both", done1, 1'b1);
            chk("err0", err0, d.err);
            chk("err1", err1, d.err);
            if (d.cyc >= 0) chk("done_cycle", cyc, d.cyc);
            chk("writes_left", exp0.size() + exp1.size(), 0);
            chk("done_release", {hold0, w0.mem_mode}, 2'b01);
            $display("done at cycle %0d err=%0b", cyc, err0);
          end
        end
      end
    end
  end

  initial begin
    #12;
    chk_reset("rst0");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // add r2,r3 : one word, checksum 01^04^43 = 46
    wtab[0] = 32'h04430000;
    frame(1, 8'h46, 1'b0, 1'b0, 1'b0);

    // three words, continuous: 03^44^00^00 = 47
    wtab[0] = 32'h11223344; wtab[1] = 32'hA5A5A5A5; wtab[2] = 32'h0F0F0F0F;
    frame(3, 8'h47, 1'b0, 1'b0, 1'b0);

    // gaps on in_valid: 02^22^04 = 24
    wtab[0] = 32'hDEADBEEF; wtab[1] = 32'h01020304;
    frame(2, 8'h24, 1'b0, 1'b1, 1'b0);

    // bad checksum (46 + 1); words still written, err sticky
    wtab[0] = 32'h04430000;
    frame(1, 8'h47, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("err_sticky", {err0, err1}, 2'b11);
    frame(1, 8'h46, 1'b0, 1'b0, 1'b0);

    // wrap on dut1 (254,255,0) with a stray start mid-DATA: 03^C9^08^00 = C2
    wtab[0] = 32'hCAFEF00D; wtab[1] = 32'h12345678; wtab[2] = 32'h00000000;
    frame(3, 8'hC2, 1'b0, 1'b0, 1'b1);

    // empty frame
    frame(0, 8'h00, 1'b0, 1'b0, 1'b0);

    // asynchronous reset mid-word
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'h01;
    @(negedge clk);
    in_data = 8'hAA;
    @(negedge clk);
    in_data = 8'hBB;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_hold", hold0, 1'b1);
    #2 rst = 1'b1;
    #1 chk_reset("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    wtab[0] = 32'h04430000;
    frame(1, 8'h46, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("tail_writes", exp0.size() + exp1.size() + expd.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
